frame_assembler_6409: RTL and testbench

//   Consumes 16-bit words and their data_ready strobe from the HD-6409 decoder.

---
 rtl/decode_6409_pkg.sv | 20 ++
 rtl/sync_fifo_commit.sv | 81 ++++++++
 rtl/frame_assembler_6409.sv | 155 +++++++++++++++
 tb/tb_frame_assembler_6409.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_6409_pkg.sv
// rtl/decode_6409_pkg.sv - shared types and constants for the HD-6409 frame assembler
package decode_6409_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CKSUM   = 2'd2
   } state_t;

   localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;
   localparam int          ENTRY_W       = 18;

   // One buffer entry: frame markers plus the payload word.
   typedef struct packed {
      logic        sof;
      logic        eof;
      logic [15:0] data;
   } entry_t;

endpackage

// File: rtl/sync_fifo_commit.sv
// rtl/sync_fifo_commit.sv - FIFO with speculative writes, commit and rollback
//
// Purpose: buffers frame entries. Writes land at wr_ptr speculatively; only
// [rd_ptr, commit_ptr) is visible to the reader. A frame is either committed
// (commit_ptr <= wr_ptr) or rolled back (wr_ptr <= start_ptr).
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   wr_en       write wr_data at wr_ptr, advance wr_ptr
//   wr_data     entry to write
//   mark        snapshot wr_ptr as the start of the current frame
//   rollback    discard speculative words back to the snapshot
//   commit      publish all written words to the reader
//   rd_en       reader accepts the head entry (ignored when empty)
//   rd_data     head entry (zero when empty)
//   rd_valid    committed data available
//   level       committed words not yet read
//   full        written-but-unread words (committed or not) fill the buffer
module sync_fifo_commit
   import decode_6409_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  entry_t        wr_data,
   input  logic          mark,
   input  logic          rollback,
   input  logic          commit,
   input  logic          rd_en,
   output entry_t        rd_data,
   output logic          rd_valid,
   output logic [PW-1:0] level,
   output logic          full
);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] commit_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] start_ptr;
   entry_t        mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[PW-2:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         start_ptr  <= '0;
      end else begin
         if (rollback) begin
            wr_ptr <= start_ptr;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (mark) begin
            start_ptr <= wr_ptr;
         end
         if (commit) begin
            commit_ptr <= wr_ptr;
         end
         if (rd_en && rd_valid) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   assign rd_valid = (rd_ptr != commit_ptr);
   assign level    = commit_ptr - rd_ptr;
   // Uses this cycle's rd_ptr, so a read in the same cycle does not free space yet.
   assign full     = ((wr_ptr - rd_ptr) == PW'(DEPTH));
   // Entries in [rd_ptr, commit_ptr) are never overwritten, so this holds while stalled.
   assign rd_data  = rd_valid ? mem[rd_ptr[PW-2:0]] : '0;

endmodule

// File: rtl/frame_assembler_6409.sv
// rtl/frame_assembler_6409.sv - sync hunt, payload collection and checksum gate for 6409 words
//
// Purpose: hunts for SYNC_WORD, collects FRAME_WORDS payload words into a
// speculative buffer, then releases them only if the trailing checksum word
// equals the 16-bit sum of the payload. Bad, timed-out or overflowing frames
// are rolled back.
// Ports:
//   clock_system, rstn   clock / asynchronous active-low reset
//   word_in, word_valid  decoded word and its 1-cycle strobe
//   out_data/sof/eof     head buffered word and frame markers
//   out_valid, out_ready output handshake
//   frame_ok, frame_err  1-cycle commit / discard pulses
//   frame_count          committed frames (wrapping)
//   overflow             sticky: a frame was dropped on a full buffer
//   fifo_level           committed words not yet read
module frame_assembler_6409
   import decode_6409_pkg::*;
#(
   parameter logic [15:0] SYNC_WORD      = SYNC_WORD_DEF,
   parameter int          FRAME_WORDS    = 8,
   parameter int          FIFO_DEPTH     = 16,
   parameter int          TIMEOUT_CYCLES = 4096,
   parameter int          LW             = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clock_system,
   input  logic          rstn,
   input  logic [15:0]   word_in,
   input  logic          word_valid,
   output logic [15:0]   out_data,
   output logic          out_sof,
   output logic          out_eof,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          frame_ok,
   output logic          frame_err,
   output logic [15:0]   frame_count,
   output logic          overflow,
   output logic [LW-1:0] fifo_level
);

   localparam int CW = $clog2(FRAME_WORDS) + 1;
   localparam int IW = $clog2(TIMEOUT_CYCLES) + 1;

   state_t        state;
   logic [CW-1:0] wcnt;
   logic [15:0]   sum;
   logic [IW-1:0] idle;

   logic   is_sync, last_word, idle_hit, full, sum_match;
   logic   mark, wr_en, rollback, commit;
   entry_t wr_entry, rd_entry;

   assign is_sync   = (word_in == SYNC_WORD);
   assign last_word = (wcnt == CW'(FRAME_WORDS - 1));
   assign sum_match = (word_in == sum);
   // This idle cycle would bring the counter to TIMEOUT_CYCLES.
   assign idle_hit  = (idle == IW'(TIMEOUT_CYCLES - 1));

   assign mark     = (state == HUNT) && word_valid && is_sync;
   assign wr_en    = (state == PAYLOAD) && word_valid && !full;
   assign commit   = (state == CKSUM) && word_valid && sum_match;
   assign rollback = ((state == PAYLOAD) && word_valid && full)
                   || ((state == CKSUM) && word_valid && !sum_match)
                   || ((state != HUNT) && !word_valid && idle_hit);

   assign wr_entry = '{sof: (wcnt == '0), eof: last_word, data: word_in};

   always_ff @(posedge clock_system or negedge rstn) begin
      if (!rstn) begin
         state       <= HUNT;
         wcnt        <= '0;
         sum         <= '0;
         idle        <= '0;
         frame_ok    <= 1'b0;
         frame_err   <= 1'b0;
         frame_count <= '0;
         overflow    <= 1'b0;
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            HUNT: begin
               if (word_valid && is_sync) begin
                  state <= PAYLOAD;
                  wcnt  <= '0;
                  sum   <= '0;
                  idle  <= '0;
               end
            end
            PAYLOAD: begin
               if (word_valid) begin
                  idle <= '0;
                  if (full) begin
                     frame_err <= 1'b1;
                     overflow  <= 1'b1;
                     state     <= HUNT;
                  end else begin
                     sum  <= sum + word_in;
                     wcnt <= wcnt + 1'b1;
                     if (last_word) begin
                        state <= CKSUM;
                     end
                  end
               end else if (idle_hit) begin
                  frame_err <= 1'b1;
                  state     <= HUNT;
               end else begin
                  idle <= idle + 1'b1;
               end
            end
            CKSUM: begin
               // A word arriving on the expiry cycle takes priority over the timeout.
               if (word_valid) begin
                  if (sum_match) begin
                     frame_ok    <= 1'b1;
                     frame_count <= frame_count + 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state <= HUNT;
               end else if (idle_hit) begin
                  frame_err <= 1'b1;
                  state     <= HUNT;
               end else begin
                  idle <= idle + 1'b1;
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

   sync_fifo_commit #(
      .DEPTH (FIFO_DEPTH),
      .PW    (LW)
   ) u_fifo (
      .clk      (clock_system),
      .rst_n    (rstn),
      .wr_en    (wr_en),
      .wr_data  (wr_entry),
      .mark     (mark),
      .rollback (rollback),
      .commit   (commit),
      .rd_en    (out_ready),
      .rd_data  (rd_entry),
      .rd_valid (out_valid),
      .level    (fifo_level),
      .full     (full)
   );

   assign out_data = rd_entry.data;
   assign out_sof  = rd_entry.sof;
   assign out_eof  = rd_entry.eof;

endmodule

// File: tb/tb_frame_assembler_6409.sv
// tb/tb_frame_assembler_6409.sv - self-checking bench for frame_assembler_6409
module tb_frame_assembler_6409;

   localparam logic [15:0] SYNC = 16'hEB90;
   localparam int FW    = 8;
   localparam int DEPTH = 16;
   localparam int TO    = 4096;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [15:0]   word_in = '0;
   logic          word_valid = 1'b0;
   logic [15:0]   out_data;
   logic          out_sof, out_eof, out_valid;
   logic          out_ready = 1'b0;
   logic          frame_ok, frame_err, overflow;
   logic [15:0]   frame_count;
   logic [LW-1:0] fifo_level;

   frame_assembler_6409 #(
      .SYNC_WORD      (SYNC),
      .FRAME_WORDS    (FW),
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock_system (clk),
      .rstn         (rstn),
      .word_in      (word_in),
      .word_valid   (word_valid),
      .out_data     (out_data),
      .out_sof      (out_sof),
      .out_eof      (out_eof),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .frame_ok     (frame_ok),
      .frame_err    (frame_err),
      .frame_count  (frame_count),
      .overflow     (overflow),
      .fifo_level   (fifo_level)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [17:0] cq[$];          // committed {sof,eof,data}, head = next to read
   logic [15:0] pq[$];          // payload words of the frame being collected
   int          m_mode = 0;     // 0 waiting for sync, 1 collecting, 2 awaiting checksum
   int          m_idle = 0;
   int          m_count = 0;
   bit          m_ovf = 0;
   bit          m_ok = 0, m_err = 0;

   logic [15:0] log_q[$];       // words the DUT handed over
   int          ok_seen = 0, err_seen = 0;

   function automatic logic [15:0] pq_sum();
      logic [15:0] s = '0;
      foreach (pq[i]) s += pq[i];
      return s;
   endfunction

   task automatic model_reset();
      cq.delete(); pq.delete();
      m_mode = 0; m_idle = 0; m_count = 0; m_ovf = 0; m_ok = 0; m_err = 0;
   endtask

   task automatic model_step(input bit wv, input logic [15:0] w, input bit rdy);
      bit full_now;
      full_now = (cq.size() + pq.size()) == DEPTH;
      m_ok = 0; m_err = 0;
      if (rdy && cq.size() > 0) void'(cq.pop_front());
      if (m_mode == 0) begin
         if (wv && w == SYNC) begin m_mode = 1; pq.delete(); m_idle = 0; end
      end else if (wv) begin
         m_idle = 0;
         if (m_mode == 1) begin
            if (full_now) begin
               pq.delete(); m_err = 1; m_ovf = 1; m_mode = 0;
            end else begin
               pq.push_back(w);
               if (pq.size() == FW) m_mode = 2;
            end
         end else begin
            if (w == pq_sum()) begin
               foreach (pq[i]) cq.push_back({i == 0, i == FW - 1, pq[i]});
               m_count = (m_count + 1) & 16'hFFFF;
               m_ok = 1;
            end else begin
               m_err = 1;
            end
            pq.delete(); m_mode = 0;
         end
      end else begin
         m_idle++;
         if (m_idle == TO) begin pq.delete(); m_err = 1; m_mode = 0; end
      end
   endtask

   // Single compare process: advance the model on each edge, then check outputs.
   always @(posedge clk) begin
      if (rstn) begin
         if (out_valid && out_ready) log_q.push_back(out_data);
         model_step(word_valid, word_in, out_ready);
         #1;
         ok_seen  += int'(frame_ok);
         err_seen += int'(frame_err);
         chk("out_valid", int'(out_valid), int'(cq.size() != 0));
         if (cq.size() != 0) begin
            chk("out_data", int'(out_data), int'(cq[0][15:0]));
            chk("out_sof", int'(out_sof), int'(cq[0][17]));
            chk("out_eof", int'(out_eof), int'(cq[0][16]));
         end
         chk("fifo_level", int'(fifo_level), cq.size());
         chk("frame_ok", int'(frame_ok), int'(m_ok));
         chk("frame_err", int'(frame_err), int'(m_err));
         chk("frame_count", int'(frame_count), m_count);
         chk("overflow", int'(overflow), int'(m_ovf));
      end
   end

   // ---------------- stimulus ----------------
   int rdy_mode = 0;            // 0 always ready, 1 never, 2 toggle, 3 random

   task automatic tick(input bit wv, input logic [15:0] w);
      @(negedge clk);
      word_valid = wv;
      word_in    = w;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'b0;
         2: out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) tick(0, 16'h0);
   endtask

   task automatic send_frame(input logic [15:0] p[FW], input logic [15:0] delta, input int gap);
      logic [15:0] s = '0;
      tick(1, SYNC); idle_n(gap);
      for (int i = 0; i < FW; i++) begin
         tick(1, p[i]); idle_n(gap);
         s += p[i];
      end
      tick(1, s + delta);
   endtask

   task automatic seq_frame(input logic [15:0] base, input logic [15:0] delta);
      logic [15:0] p[FW];
      for (int i = 0; i < FW; i++) p[i] = base + 16'(i + 1);
      send_frame(p, delta, 0);
   endtask

   task automatic check_tail(input string name, input logic [15:0] base, input int first);
      for (int i = 0; i < FW; i++)
         if (first + i < log_q.size()) chk(name, int'(log_q[first + i]), int'(base) + i + 1);
         else chk(name, -1, int'(base) + i + 1);
   endtask

   initial begin
      int base_log, base_err, base_ok;
      logic [15:0] p[FW];

      // Reset state.
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_frame_count", int'(frame_count), 0);
      chk("rst_fifo_level", int'(fifo_level), 0);
      chk("rst_overflow", int'(overflow), 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // 1: good frame 1..8, checksum 0x0024.
      rdy_mode = 0;
      base_log = log_q.size();
      tick(1, SYNC);
      for (int i = 1; i <= 8; i++) tick(1, 16'(i));
      tick(1, 16'h0024);
      idle_n(12);
      chk("t1_words", log_q.size() - base_log, 8);
      check_tail("t1_data", 16'h0, base_log);
      chk("t1_count", int'(frame_count), 1);
      chk("t1_ok", ok_seen, 1);

      // 2: bad checksum, then a good frame.
      base_log = log_q.size(); base_err = err_seen;
      seq_frame(16'h0, 16'h0001);
      idle_n(4);
      chk("t2_err", err_seen - base_err, 1);
      chk("t2_nowords", log_q.size() - base_log, 0);
      chk("t2_level", int'(fifo_level), 0);
      seq_frame(16'h0, 16'h0);
      idle_n(12);
      check_tail("t2_next", 16'h0, base_log);
      chk("t2_count", int'(frame_count), 2);

      // 3: timeout after three payload words.
      base_err = err_seen;
      tick(1, SYNC); tick(1, 16'h11); tick(1, 16'h22); tick(1, 16'h33);
      idle_n(TO + 2);
      chk("t3_err", err_seen - base_err, 1);
      base_log = log_q.size();
      seq_frame(16'h0010, 16'h0);
      idle_n(12);
      check_tail("t3_next", 16'h0010, base_log);
      chk("t3_count", int'(frame_count), 3);

      // 4: overflow with the reader stalled.
      rdy_mode = 1;
      base_err = err_seen; base_log = log_q.size();
      seq_frame(16'h0100, 16'h0);
      seq_frame(16'h0200, 16'h0);
      seq_frame(16'h0300, 16'h0);
      idle_n(3);
      chk("t4_level", int'(fifo_level), 16);
      chk("t4_overflow", int'(overflow), 1);
      chk("t4_err", err_seen - base_err, 1);
      rdy_mode = 0;
      idle_n(20);
      chk("t4_drained", log_q.size() - base_log, 16);
      check_tail("t4_a", 16'h0100, base_log);
      check_tail("t4_b", 16'h0200, base_log + 8);

      // 5: noise before sync, sync value inside payload, toggling ready.
      rdy_mode = 2;
      base_log = log_q.size();
      tick(1, 16'h1234); tick(1, 16'hEB91);
      for (int i = 0; i < FW; i++) p[i] = (i % 3 == 0) ? SYNC : 16'(16'h0A00 + i);
      send_frame(p, 16'h0, 1);
      idle_n(30);
      chk("t5_words", log_q.size() - base_log, 8);
      for (int i = 0; i < FW; i++)
         if (base_log + i < log_q.size()) chk("t5_data", int'(log_q[base_log + i]), int'(p[i]));

      // 6: reset mid-payload with committed data pending.
      rdy_mode = 1;
      seq_frame(16'h0400, 16'h0);
      tick(1, SYNC); tick(1, 16'h0501); tick(1, 16'h0502);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("t6_valid", int'(out_valid), 0);
      chk("t6_level", int'(fifo_level), 0);
      chk("t6_count", int'(frame_count), 0);
      chk("t6_overflow", int'(overflow), 0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      rdy_mode = 0;
      base_log = log_q.size();
      seq_frame(16'h0600, 16'h0);
      idle_n(12);
      chk("t6_words", log_q.size() - base_log, 8);
      check_tail("t6_data", 16'h0600, base_log);
      chk("t6_count_after", int'(frame_count), 1);

      // Random frames, noise, gaps and ready patterns against the model.
      rdy_mode = 3;
      for (int f = 0; f < 40; f++) begin
         int n = $urandom_range(0, 3);
         for (int k = 0; k < n; k++) tick(1, 16'($urandom));
         for (int i = 0; i < FW; i++) p[i] = ($urandom_range(0, 15) == 0) ? SYNC : 16'($urandom);
         send_frame(p, ($urandom_range(0, 9) < 7) ? 16'h0 : 16'($urandom_range(1, 65535)),
                    $urandom_range(0, 2));
         idle_n($urandom_range(0, 6));
      end
      rdy_mode = 0;
      idle_n(40);
      chk("rand_drained", int'(fifo_level), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
